conf_disp_divide_pipe: RTL and testbench
========================================

Name: conf_disp_divide_pipe

Overview:
Confidence-weighted disparity normaliser: computes out_disp = in_conf_disp / (in_conf + 1), saturated to DISP_BITS.
- Uses a radix-2 restoring divider built in-house, one quotient bit per stage; no vendor IP.
- Adds valid/ready backpressure, a low-confidence reject and optional round-to-nearest.
- Sits after the confidence/disparity accumulator in the disparity filtering chain, feeding the disparity map writer.

Parameters:
DISP_BITS, 5, output disparity width; quotient saturates at 2^DISP_BITS-1
CONF_BITS, 8, confidence width; denominator is in_conf+1 (CONF_BITS+1 bits)
MIN_CONF, 0, inputs with in_conf < MIN_CONF are flagged low-confidence; 0 disables the check

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_conf  in  CONF_BITS  accumulated confidence
in_conf_disp  in  CONF_BITS+DISP_BITS  accumulated confidence*disparity
in_valid  in  1  input beat valid
in_ready  out  1  block accepts a beat this cycle
out_disp  out  DISP_BITS  normalised disparity
out_low_conf  out  1  beat rejected for low confidence (out_disp forced 0)
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts output

Behaviour:
- Interface: reset is synchronous, active-high; clock is clk.
- Reset values: out_valid=0, out_disp=0, out_low_conf=0. All stage valids clear. in_ready=1 from the first cycle after reset.
- Pipeline advance: adv = !out_valid || out_ready. in_ready = adv.
  - A beat is accepted when in_valid && in_ready.
  - When adv=0, every stage holds, including bubbles.
  - No beat is ever dropped or duplicated; order is preserved.
- Latency with no stall: DISP_BITS+2 cycles from acceptance to out_valid (7 at default).
  - Stage 0: input register. D = in_conf+1, R = in_conf_disp.
  - sat = (R >= D<<DISP_BITS). low = (in_conf < MIN_CONF).
  - Stages 1..DISP_BITS: stage k resolves quotient bit DISP_BITS-k. If R >= D<<(DISP_BITS-k), then R -= D<<(DISP_BITS-k) and the bit is 1; otherwise the bit is 0.
  - Output register: out_disp = low ? 0 : sat ? 2^DISP_BITS-1 : q. out_low_conf = low.
- Width rules:
  - The remainder register is CONF_BITS+DISP_BITS bits.
  - Shifted-denominator compares are done at CONF_BITS+DISP_BITS+1 bits.
  - in_conf=2^CONF_BITS-1 must not overflow D; D uses CONF_BITS+1 bits.
- Boundaries:
  - in_conf=0 gives D=1, so no divide-by-zero.
  - in_conf_disp=0 gives 0.
  - Saturation and low-confidence on the same beat: low_conf wins, out_disp=0.
  - Simultaneous accept and output pop in one cycle is allowed, giving full throughput of 1 beat/cycle.
- Reset mid-operation: all in-flight beats are discarded and no output is produced for them. out_valid drops the cycle after reset is asserted.

Optional Feature:
Macro CONF_DISP_DIV_ROUND_EN.
- Defined: after the last stage, q += 1 if 2*R >= D (round half up). The result then saturates at 2^DISP_BITS-1. Latency is unchanged because the increment is in the output register stage.
- Undefined: truncating division (floor), which is bit-identical to the legacy divider.

Decomposition:
- Package conf_disp_pkg: DISP_BITS_DEFAULT=5, CONF_BITS_DEFAULT=8, and function sat_max(bits) returning 2^bits-1.
- Sub-module conf_disp_div_stage, one restoring step, parameterised by shift amount and widths:
  - Inputs: valid, D, R, q, sat, low, adv.
  - Outputs: the registered versions of the same fields.
- The top instantiates DISP_BITS copies of conf_disp_div_stage in a generate loop.

Test Plan:
- Basic divide: conf=3, conf_disp=40, out_ready=1 -> out_disp=10, low_conf=0, out_valid exactly 7 cycles after accept.
- Rounding: conf=3, conf_disp=42 -> 10 without CONF_DISP_DIV_ROUND_EN, 11 with it. conf=255, conf_disp=8191 -> 31 in both builds (saturation).
- Saturation and D=1: conf=0, conf_disp=255 -> 31. conf=0, conf_disp=0 -> 0. conf=0, conf_disp=31 -> 31.
- Low confidence: MIN_CONF=2. conf=1, conf_disp=100 -> out_disp=0, low_conf=1. conf=2, conf_disp=30 -> 10, low_conf=0.
- Backpressure: stream 20 random beats back-to-back while out_ready toggles 0 for 5 cycles, 1 for 3 cycles, repeating -> all 20 results match the reference model, in order; in_ready=0 exactly when out_valid && !out_ready.
- Reset mid-flight: accept 4 beats, assert reset for 1 cycle at cycle 3 -> no out_valid for those beats. The next beat (conf=1, conf_disp=20) -> 10 after 7 cycles.

Source files
------------

// File: rtl/conf_disp_pkg.sv
// ---------------------------------------------------------------------------
// conf_disp_pkg
//   Shared constants and helpers for the confidence-weighted disparity
//   normaliser (conf_disp_divide_pipe and its divider stages).
//
//   DISP_BITS_DEFAULT : default output disparity width
//   CONF_BITS_DEFAULT : default accumulated-confidence width
//   sat_max(bits)     : all-ones value of a 'bits'-wide field (2^bits-1)
// ---------------------------------------------------------------------------
package conf_disp_pkg;

  localparam int DISP_BITS_DEFAULT = 5;
  localparam int CONF_BITS_DEFAULT = 8;

  function automatic int sat_max(input int bits);
    return (1 << bits) - 1;
  endfunction

endpackage

// File: rtl/conf_disp_div_stage.sv
// ---------------------------------------------------------------------------
// conf_disp_div_stage
//   One step of the radix-2 restoring divider. Compares the running
//   remainder against the denominator shifted left by SHIFT; if it fits,
//   subtracts it and sets quotient bit SHIFT. All fields are registered and
//   advance together only when 'adv' is high, so a stalled pipe holds every
//   beat (and every bubble) in place.
//
// Parameters:
//   SHIFT     : quotient bit resolved by this stage
//   CONF_BITS : confidence width (denominator is CONF_BITS+1 bits)
//   DISP_BITS : quotient width
//
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   adv                     : pipeline advance enable
//   prev_valid/d/r/q/sat/low: fields from the previous stage
//   valid/d/r/q/sat/low     : registered fields for the next stage
// ---------------------------------------------------------------------------
module conf_disp_div_stage #(
  parameter int SHIFT     = 0,
  parameter int CONF_BITS = 8,
  parameter int DISP_BITS = 5
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           adv,
  input  logic                           prev_valid,
  input  logic [CONF_BITS:0]             prev_d,
  input  logic [CONF_BITS+DISP_BITS-1:0] prev_r,
  input  logic [DISP_BITS-1:0]           prev_q,
  input  logic                           prev_sat,
  input  logic                           prev_low,
  output logic                           valid,
  output logic [CONF_BITS:0]             d,
  output logic [CONF_BITS+DISP_BITS-1:0] r,
  output logic [DISP_BITS-1:0]           q,
  output logic                           sat,
  output logic                           low
);

  localparam int RW = CONF_BITS + DISP_BITS;  // remainder width
  localparam int CW = RW + 1;                 // compare width
  localparam logic [DISP_BITS-1:0] Q_BIT = DISP_BITS'(1) << SHIFT;

  logic [CW-1:0]        d_shift;
  logic                 take;
  logic [RW-1:0]        r_sub;
  logic [RW-1:0]        r_next;
  logic [DISP_BITS-1:0] q_next;

  // The extra compare bit keeps the shifted denominator from wrapping.
  assign d_shift = CW'(prev_d) << SHIFT;
  assign take    = {1'b0, prev_r} >= d_shift;
  // Only used when take=1, in which case d_shift fits in the remainder.
  assign r_sub   = prev_r - d_shift[RW-1:0];
  assign r_next  = take ? r_sub : prev_r;
  assign q_next  = take ? (prev_q | Q_BIT) : prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
    end else if (adv) begin
      valid <= prev_valid;
    end
  end

  // Data fields need no reset: they are only meaningful alongside valid.
  always_ff @(posedge clk) begin
    if (adv) begin
      d   <= prev_d;
      r   <= r_next;
      q   <= q_next;
      sat <= prev_sat;
      low <= prev_low;
    end
  end

endmodule

// File: rtl/conf_disp_divide_pipe.sv
// ---------------------------------------------------------------------------
// conf_disp_divide_pipe
//   Confidence-weighted disparity normaliser:
//     out_disp = in_conf_disp / (in_conf + 1), saturated to DISP_BITS.
//   Pipeline: input register, DISP_BITS restoring-divider stages (one
//   quotient bit each, MSB first), output register. Latency is DISP_BITS+2
//   cycles from acceptance; throughput is one beat per cycle. The whole pipe
//   advances only when the output register is empty or being popped.
//
//   Build option CONF_DISP_DIV_ROUND_EN: when defined, the quotient is
//   rounded half-up (q += 1 if 2*R >= D) in the output register stage, then
//   saturated. When undefined, the result is the truncated (floor) quotient.
//
// Parameters:
//   DISP_BITS : output disparity width
//   CONF_BITS : confidence width
//   MIN_CONF  : beats with in_conf < MIN_CONF are rejected; 0 disables
//
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   in_conf      : accumulated confidence
//   in_conf_disp : accumulated confidence*disparity
//   in_valid     : input beat valid
//   in_ready     : a beat is accepted this cycle when in_valid is also high
//   out_disp     : normalised disparity (0 for low-confidence beats)
//   out_low_conf : beat rejected for low confidence
//   out_valid    : output beat valid
//   out_ready    : downstream accepts the output beat
// ---------------------------------------------------------------------------
module conf_disp_divide_pipe
  import conf_disp_pkg::*;
#(
  parameter int DISP_BITS = DISP_BITS_DEFAULT,
  parameter int CONF_BITS = CONF_BITS_DEFAULT,
  parameter int MIN_CONF  = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [CONF_BITS-1:0]           in_conf,
  input  logic [CONF_BITS+DISP_BITS-1:0] in_conf_disp,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [DISP_BITS-1:0]           out_disp,
  output logic                           out_low_conf,
  output logic                           out_valid,
  input  logic                           out_ready
);

  localparam int RW = CONF_BITS + DISP_BITS;  // remainder width
  localparam int CW = RW + 1;                 // compare width
  localparam int DW = CONF_BITS + 1;          // denominator width
  localparam logic [DISP_BITS-1:0] DISP_MAX = DISP_BITS'(sat_max(DISP_BITS));

  logic adv;

  // Stall only when a finished beat is waiting and downstream refuses it.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // -------------------------------------------------------------------------
  // Stage 0: input register
  // -------------------------------------------------------------------------
  logic [DW-1:0] in_d;
  logic          in_sat;
  logic          in_low;

  // in_conf = 2^CONF_BITS-1 needs the extra denominator bit.
  assign in_d   = {1'b0, in_conf} + DW'(1);
  // Quotient would not fit in DISP_BITS: flag it now, clamp at the output.
  assign in_sat = {1'b0, in_conf_disp} >= (CW'(in_d) << DISP_BITS);

  generate
    if (MIN_CONF > 0) begin : g_low_chk
      assign in_low = int'(in_conf) < MIN_CONF;
    end else begin : g_no_low_chk
      assign in_low = 1'b0;
    end
  endgenerate

  logic                 s0_valid;
  logic [DW-1:0]        s0_d;
  logic [RW-1:0]        s0_r;
  logic                 s0_sat;
  logic                 s0_low;

  always_ff @(posedge clk) begin
    if (reset) begin
      s0_valid <= 1'b0;
    end else if (adv) begin
      s0_valid <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      s0_d   <= in_d;
      s0_r   <= in_conf_disp;
      s0_sat <= in_sat;
      s0_low <= in_low;
    end
  end

  // -------------------------------------------------------------------------
  // Stages 1..DISP_BITS: restoring divider, element k is stage k's output
  // -------------------------------------------------------------------------
  logic                 st_valid [0:DISP_BITS];
  logic [DW-1:0]        st_d     [0:DISP_BITS];
  logic [RW-1:0]        st_r     [0:DISP_BITS];
  logic [DISP_BITS-1:0] st_q     [0:DISP_BITS];
  logic                 st_sat   [0:DISP_BITS];
  logic                 st_low   [0:DISP_BITS];

  assign st_valid[0] = s0_valid;
  assign st_d[0]     = s0_d;
  assign st_r[0]     = s0_r;
  assign st_q[0]     = '0;
  assign st_sat[0]   = s0_sat;
  assign st_low[0]   = s0_low;

  generate
    for (genvar gi = 0; gi < DISP_BITS; gi++) begin : g_stage
      // Stage gi+1 resolves quotient bit DISP_BITS-1-gi (MSB first).
      conf_disp_div_stage #(
        .SHIFT     (DISP_BITS - 1 - gi),
        .CONF_BITS (CONF_BITS),
        .DISP_BITS (DISP_BITS)
      ) u_stage (
        .clk        (clk),
        .reset      (reset),
        .adv        (adv),
        .prev_valid (st_valid[gi]),
        .prev_d     (st_d[gi]),
        .prev_r     (st_r[gi]),
        .prev_q     (st_q[gi]),
        .prev_sat   (st_sat[gi]),
        .prev_low   (st_low[gi]),
        .valid      (st_valid[gi+1]),
        .d          (st_d[gi+1]),
        .r          (st_r[gi+1]),
        .q          (st_q[gi+1]),
        .sat        (st_sat[gi+1]),
        .low        (st_low[gi+1])
      );
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Output register: optional rounding, saturation, low-confidence override
  // -------------------------------------------------------------------------
  logic [DISP_BITS-1:0] q_final;

`ifdef CONF_DISP_DIV_ROUND_EN
  logic [CW-1:0]        rem2;
  logic                 round_up;
  logic [DISP_BITS:0]   q_inc;

  // Final remainder is < D, so 2*R fits in one extra bit.
  assign rem2     = {st_r[DISP_BITS], 1'b0};
  assign round_up = rem2 >= CW'(st_d[DISP_BITS]);
  assign q_inc    = {1'b0, st_q[DISP_BITS]} + {{DISP_BITS{1'b0}}, 1'b1};
  assign q_final  = !round_up        ? st_q[DISP_BITS] :
                    q_inc[DISP_BITS] ? DISP_MAX        :
                                       q_inc[DISP_BITS-1:0];
`else
  logic unused_rem;

  // Truncating build: the final remainder and denominator are not needed.
  assign q_final    = st_q[DISP_BITS];
  assign unused_rem = ^{st_r[DISP_BITS], st_d[DISP_BITS]};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid    <= 1'b0;
      out_disp     <= '0;
      out_low_conf <= 1'b0;
    end else if (adv) begin
      out_valid    <= st_valid[DISP_BITS];
      out_low_conf <= st_low[DISP_BITS];
      // Low confidence outranks saturation.
      if (st_low[DISP_BITS]) begin
        out_disp <= '0;
      end else if (st_sat[DISP_BITS]) begin
        out_disp <= DISP_MAX;
      end else begin
        out_disp <= q_final;
      end
    end
  end

endmodule

// File: tb/tb_conf_disp_divide_pipe.sv
// ---------------------------------------------------------------------------
// tb_conf_disp_divide_pipe
//   Self-checking bench for conf_disp_divide_pipe. Two instances share the
//   stimulus: dut (MIN_CONF=0) and dut_lc (MIN_CONF=2). Expected results for
//   both are computed from an integer reference model when a beat is
//   accepted and popped from a queue when the output handshake completes.
//   Honours CONF_DISP_DIV_ROUND_EN in the reference model.
// ---------------------------------------------------------------------------
module tb_conf_disp_divide_pipe;

  localparam int DB = 5;
  localparam int CB = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [CB-1:0] in_conf = '0;
  logic [CB+DB-1:0] in_conf_disp = '0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;

  logic          in_ready, out_low_conf, out_valid;
  logic [DB-1:0] out_disp;
  logic          lc_in_ready, lc_out_low_conf, lc_out_valid;
  logic [DB-1:0] lc_out_disp;

  always #5 clk = ~clk;

  conf_disp_divide_pipe #(.DISP_BITS(DB), .CONF_BITS(CB), .MIN_CONF(0)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_conf      (in_conf),
    .in_conf_disp (in_conf_disp),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_disp     (out_disp),
    .out_low_conf (out_low_conf),
    .out_valid    (out_valid),
    .out_ready    (out_ready)
  );

  conf_disp_divide_pipe #(.DISP_BITS(DB), .CONF_BITS(CB), .MIN_CONF(2)) dut_lc (
    .clk          (clk),
    .reset        (reset),
    .in_conf      (in_conf),
    .in_conf_disp (in_conf_disp),
    .in_valid     (in_valid),
    .in_ready     (lc_in_ready),
    .out_disp     (lc_out_disp),
    .out_low_conf (lc_out_low_conf),
    .out_valid    (lc_out_valid),
    .out_ready    (out_ready)
  );

  typedef struct packed {
    logic [DB-1:0] disp;
    logic          low;
    logic [DB-1:0] disp_lc;
    logic          low_lc;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reference: plain integer division, optional round-half-up, clamp, reject.
  function automatic void calc(input int conf, input int cd, input int minc,
                               output logic [DB-1:0] disp, output logic low);
    int d, q, r;
    d = conf + 1;
    q = cd / d;
    r = cd % d;
`ifdef CONF_DISP_DIV_ROUND_EN
    if (2 * r >= d) q = q + 1;
`endif
    if (q > 31) q = 31;
    low = (conf < minc);
    if (low) q = 0;
    disp = q[DB-1:0];
  endfunction

  // Output monitor: handshake and scoreboard comparisons on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      check("in_ready_rule", {31'b0, in_ready}, {31'b0, !(out_valid && !out_ready)});
      check("lc_valid_match", {31'b0, lc_out_valid}, {31'b0, out_valid});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", {31'b0, out_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("disp", {27'b0, out_disp}, {27'b0, e.disp});
          check("low_conf", {31'b0, out_low_conf}, {31'b0, e.low});
          check("disp_lc", {27'b0, lc_out_disp}, {27'b0, e.disp_lc});
          check("low_conf_lc", {31'b0, lc_out_low_conf}, {31'b0, e.low_lc});
        end
      end
    end
  end

  // Present a beat and hold it until accepted; caller must be at posedge+1.
  task automatic send(input int conf, input int cd);
    bit   acc;
    int   guard;
    exp_t e;
    in_conf      = conf[CB-1:0];
    in_conf_disp = cd[CB+DB-1:0];
    in_valid     = 1'b1;
    calc(conf, cd, 0, e.disp, e.low);
    calc(conf, cd, 2, e.disp_lc, e.low_lc);
    guard = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!acc && guard < 200);
    if (!acc) check("accept_timeout", {31'b0, in_ready}, 32'd1);
    else exp_q.push_back(e);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 300) begin
      @(posedge clk);
      #1;
      g++;
    end
    check("drain", exp_q.size(), 32'd0);
  endtask

  task automatic single(input int conf, input int cd);
    send(conf, cd);
    in_valid = 1'b0;
    drain();
  endtask

  // Single beat with out_ready=1: measure cycles from acceptance to out_valid.
  task automatic lat_test(input int conf, input int cd);
    int lat;
    send(conf, cd);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, 32'd7);
    drain();
  endtask

  initial begin
    int seen;
    int c, cd;

    // Reset state
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_disp", {27'b0, out_disp}, 32'd0);
    check("rst_low_conf", {31'b0, out_low_conf}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Basic divide with latency
    lat_test(3, 40);
    // Rounding / saturation
    single(3, 42);
    single(255, 8191);
    // D = 1 cases
    single(0, 255);
    single(0, 0);
    single(0, 31);
    // Low confidence boundary (checked on dut_lc)
    single(1, 100);
    single(2, 30);

    // Backpressure: 20 back-to-back random beats, out_ready 0x5 / 1x3
    fork
      begin
        repeat (12) begin
          out_ready = 1'b0;
          repeat (5) begin @(posedge clk); #1; end
          out_ready = 1'b1;
          repeat (3) begin @(posedge clk); #1; end
        end
        out_ready = 1'b1;
      end
      begin
        for (int i = 0; i < 20; i++) begin
          c  = $urandom_range(0, 255);
          cd = $urandom_range(0, (c + 1) * 36);
          if (cd > 8191) cd = 8191;
          send(c, cd);
        end
        in_valid = 1'b0;
      end
    join
    drain();

    // Reset mid-flight: in-flight beats must vanish
    for (int i = 0; i < 4; i++) send(3 + i, 40 + i);
    in_valid = 1'b0;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_flush_valid", {31'b0, out_valid}, 32'd0);
    seen = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("no_out_after_reset", seen, 32'd0);
    lat_test(1, 20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, %0d tests run", tests);
    $fatal(1, "timeout");
  end

endmodule
